te_multiplier_pipe: RTL and testbench

Parametrised, handshaked successor to the transmission-estimate multiplier. Computes ω·Fc/Ac per pixel lane as Fc × Inv_Ac, with saturation instead of wrap-around. Optionally returns the transmission t = max(1 − product, T_MIN). Sits between the dark-channel min filter and the scene-recovery divider, with valid/ready backpressure and frame-synchronous Inv_Ac update.

---
 rtl/te_pkg.sv | 29 ++
 rtl/te_lane_mac.sv | 79 +++++++
 rtl/te_multiplier_pipe.sv | 162 ++++++++++++++++
 tb/tb_te_multiplier_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/te_pkg.sv
`default_nettype none
// ============================================================================
// Module      : te_pkg
// Description : Shared constants and types for the transmission-estimate
//               multiplier pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package te_pkg;

    localparam int unsigned PIX_W_DEFAULT  = 8;
    localparam int unsigned INV_W_DEFAULT  = 10;
    localparam int unsigned FRAC_W_DEFAULT = 10;
    localparam int unsigned LANES_DEFAULT  = 1;

    localparam int unsigned ONE_Q10        = 1023;
    localparam int unsigned T_MIN_DEFAULT  = 102;

    localparam logic MODE_PRODUCT = 1'b0;
    localparam logic MODE_TRANS   = 1'b1;

    // Per-beat sideband carried alongside the lane data.
    typedef struct packed {
        logic mode;
        logic sof;
        logic eol;
    } te_side_t;

endpackage
`default_nettype wire

// File: rtl/te_lane_mac.sv
`default_nettype none
// ============================================================================
// Module      : te_lane_mac
// Description : One pixel lane: Fc capture, Fc x Inv_Ac multiply, saturation
//               and optional transmission clamp, each stage enable-gated.
// Revision    : 1.0 - initial release
// ============================================================================
module te_lane_mac
    import te_pkg::*;
#(
    parameter int unsigned PIX_W  = PIX_W_DEFAULT,
    parameter int unsigned INV_W  = INV_W_DEFAULT,
    parameter int unsigned FRAC_W = FRAC_W_DEFAULT,
    parameter int unsigned T_MIN  = T_MIN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_s1_en,
    input  logic              i_s2_en,
    input  logic              i_s3_en,
    input  logic [PIX_W-1:0]  i_fc,
    input  logic [INV_W-1:0]  i_inv_s1,
    input  logic              i_mode_s2,
    output logic [FRAC_W-1:0] o_data,
    output logic              o_sat
);

    localparam int unsigned PROD_W = PIX_W + INV_W;

    localparam logic [FRAC_W-1:0] c_one_f = '1;
    localparam logic [PROD_W-1:0] c_one_p = PROD_W'(c_one_f);
    localparam logic [FRAC_W-1:0] c_tmin  = FRAC_W'(T_MIN);

    logic [PIX_W-1:0]  r_fc_s1;
    logic [PROD_W-1:0] r_prod_s2;
    logic [FRAC_W-1:0] r_data;
    logic              r_sat;

    logic              w_sat;
    logic [FRAC_W-1:0] w_p;
    logic [FRAC_W-1:0] w_t;
    logic [FRAC_W-1:0] w_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fc_s1   <= '0;
            r_prod_s2 <= '0;
            r_data    <= '0;
            r_sat     <= 1'b0;
        end else begin
            if (i_s1_en) begin
                r_fc_s1 <= i_fc;
            end
            if (i_s2_en) begin
                r_prod_s2 <= PROD_W'(r_fc_s1) * PROD_W'(i_inv_s1);
            end
            if (i_s3_en) begin
                r_data <= w_res;
                r_sat  <= w_sat;
            end
        end
    end

    // The product saturates to just under 1.0 rather than wrapping.
    always_comb begin
        w_sat = (r_prod_s2 > c_one_p);
        w_p   = w_sat ? c_one_f : r_prod_s2[FRAC_W-1:0];
        w_t   = c_one_f - w_p;
        w_res = w_p;
        if (i_mode_s2 == MODE_TRANS) begin
            w_res = (w_t < c_tmin) ? c_tmin : w_t;
        end
    end

    assign o_data = r_data;
    assign o_sat  = r_sat;

endmodule
`default_nettype wire

// File: rtl/te_multiplier_pipe.sv
`default_nettype none
// ============================================================================
// Module      : te_multiplier_pipe
// Description : Handshaked 3-stage Fc x Inv_Ac multiplier with frame-synchronous
//               Inv_Ac update and optional transmission output.
// Revision    : 1.0 - initial release
// ============================================================================
module te_multiplier_pipe
    import te_pkg::*;
#(
    parameter int unsigned PIX_W  = PIX_W_DEFAULT,
    parameter int unsigned INV_W  = INV_W_DEFAULT,
    parameter int unsigned FRAC_W = FRAC_W_DEFAULT,
    parameter int unsigned LANES  = LANES_DEFAULT,
    parameter int unsigned T_MIN  = T_MIN_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [INV_W-1:0]         inv_ac_in,
    input  logic                     inv_ac_load,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sof,
    input  logic                     in_eol,
    input  logic [LANES*PIX_W-1:0]   in_fc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic [LANES*FRAC_W-1:0]  out_data,
    output logic [LANES-1:0]         out_sat
);

    logic r_v1;
    logic r_v2;
    logic r_v3;

    te_side_t r_side1;
    te_side_t r_side2;
    logic     r_sof3;
    logic     r_eol3;

    logic [INV_W-1:0] r_inv_pend;
    logic             r_pend_flag;
    logic [INV_W-1:0] r_inv_act;
    logic [INV_W-1:0] r_inv_s1;

    logic             w_s1_free;
    logic             w_s2_free;
    logic             w_s3_free;
    logic             w_accept;
    logic             w_s2_load;
    logic             w_s3_load;
    logic             w_sof_accept;
    logic [INV_W-1:0] w_inv_use;

    // A stage may take new data when it is empty or its content moves on.
    assign w_s3_free = !r_v3 || out_ready;
    assign w_s2_free = !r_v2 || w_s3_free;
    assign w_s1_free = !r_v1 || w_s2_free;
    assign in_ready  = w_s1_free;

    assign w_accept     = in_valid && w_s1_free;
    assign w_s2_load    = w_s2_free && r_v1;
    assign w_s3_load    = w_s3_free && r_v2;
    assign w_sof_accept = w_accept && in_sof;

    // A load coinciding with the sof beat bypasses the pending register.
    always_comb begin
        w_inv_use = r_inv_act;
        if (w_sof_accept) begin
            if (inv_ac_load) begin
                w_inv_use = inv_ac_in;
            end else if (r_pend_flag) begin
                w_inv_use = r_inv_pend;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inv_pend  <= '0;
            r_pend_flag <= 1'b0;
            r_inv_act   <= '0;
        end else begin
            if (inv_ac_load) begin
                r_inv_pend <= inv_ac_in;
            end
            if (w_sof_accept) begin
                r_inv_act   <= w_inv_use;
                r_pend_flag <= 1'b0;
            end else if (inv_ac_load) begin
                r_pend_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_side1  <= '0;
            r_side2  <= '0;
            r_sof3   <= 1'b0;
            r_eol3   <= 1'b0;
            r_inv_s1 <= '0;
        end else begin
            if (w_s1_free) begin
                r_v1 <= in_valid;
            end
            if (w_s2_free) begin
                r_v2 <= r_v1;
            end
            if (w_s3_free) begin
                r_v3 <= r_v2;
            end
            if (w_accept) begin
                r_side1.mode <= mode;
                r_side1.sof  <= in_sof;
                r_side1.eol  <= in_eol;
                r_inv_s1     <= w_inv_use;
            end
            if (w_s2_load) begin
                r_side2 <= r_side1;
            end
            if (w_s3_load) begin
                r_sof3 <= r_side2.sof;
                r_eol3 <= r_side2.eol;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            te_lane_mac #(
                .PIX_W  (PIX_W),
                .INV_W  (INV_W),
                .FRAC_W (FRAC_W),
                .T_MIN  (T_MIN)
            ) u_lane (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_s1_en   (w_accept),
                .i_s2_en   (w_s2_load),
                .i_s3_en   (w_s3_load),
                .i_fc      (in_fc[gi*PIX_W +: PIX_W]),
                .i_inv_s1  (r_inv_s1),
                .i_mode_s2 (r_side2.mode),
                .o_data    (out_data[gi*FRAC_W +: FRAC_W]),
                .o_sat     (out_sat[gi])
            );
        end
    endgenerate

    assign out_valid = r_v3;
    assign out_sof   = r_sof3;
    assign out_eol   = r_eol3;

endmodule
`default_nettype wire

// File: tb/tb_te_multiplier_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_te_multiplier_pipe
// Description : Directed-vector bench for te_multiplier_pipe with two lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_te_multiplier_pipe;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned INV_W  = 10;
    localparam int unsigned FRAC_W = 10;
    localparam int unsigned LANES  = 2;
    localparam int unsigned T_MIN  = 102;
    localparam int          NV     = 11;

    logic                    clk;
    logic                    rst_n;
    logic                    mode;
    logic [INV_W-1:0]        inv_ac_in;
    logic                    inv_ac_load;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sof;
    logic                    in_eol;
    logic [LANES*PIX_W-1:0]  in_fc;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_sof;
    logic                    out_eol;
    logic [LANES*FRAC_W-1:0] out_data;
    logic [LANES-1:0]        out_sat;

    te_multiplier_pipe #(
        .PIX_W  (PIX_W),
        .INV_W  (INV_W),
        .FRAC_W (FRAC_W),
        .LANES  (LANES),
        .T_MIN  (T_MIN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .inv_ac_in   (inv_ac_in),
        .inv_ac_load (inv_ac_load),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sof      (in_sof),
        .in_eol      (in_eol),
        .in_fc       (in_fc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sof     (out_sof),
        .out_eol     (out_eol),
        .out_data    (out_data),
        .out_sat     (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [9:0] inv;
        logic       sof;
        logic       eol;
        logic       md;
        logic [7:0] fc0;
        logic [7:0] fc1;
        logic [9:0] e0;
        logic [9:0] e1;
        logic [1:0] esat;
    } vec_t;

    vec_t vecs [NV];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_load(input logic [9:0] v);
        inv_ac_in   = v;
        inv_ac_load = 1'b1;
        @(negedge clk);
        inv_ac_load = 1'b0;
    endtask

    // Called on a negedge; returns on the negedge after the beat was taken.
    task automatic send_beat(input logic ld, input logic [9:0] inv, input logic sof,
                             input logic eol, input logic md,
                             input logic [7:0] fc0, input logic [7:0] fc1);
        int n;
        in_valid    = 1'b1;
        inv_ac_load = ld;
        inv_ac_in   = inv;
        in_sof      = sof;
        in_eol      = eol;
        mode        = md;
        in_fc       = {fc1, fc0};
        n = 0;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        inv_ac_load = 1'b0;
        in_sof      = 1'b0;
        in_eol      = 1'b0;
    endtask

    task automatic expect_out(input logic [9:0] e0, input logic [9:0] e1, input logic [1:0] esat,
                              input logic sof, input logic eol, input string name,
                              output int lat);
        int n;
        logic [9:0] d0;
        logic [9:0] d1;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
            lat = -1;
        end else begin
            lat = n + 1;
            d0 = out_data[9:0];
            d1 = out_data[19:10];
            check({name, "_lane0"}, 32'(d0), 32'(e0));
            check({name, "_lane1"}, 32'(d1), 32'(e1));
            check({name, "_sat"},   32'(out_sat), 32'(esat));
            check({name, "_sof"},   32'(out_sof), 32'(sof));
            check({name, "_eol"},   32'(out_eol), 32'(eol));
            @(negedge clk);
        end
    endtask

    initial begin
        int   lat;
        int   cyc;
        int   tx;
        int   rx;
        logic acc;
        logic saw_low;
        logic extra;

        //            ld    inv     sof   eol   md    fc0     fc1     e0        e1        sat
        vecs[0]  = '{1'b1, 10'd4,  1'b1, 1'b0, 1'b0, 8'd200, 8'd0,   10'd800,  10'd0,    2'b00};
        vecs[1]  = '{1'b0, 10'd0,  1'b0, 1'b1, 1'b1, 8'd200, 8'd0,   10'd223,  10'd1023, 2'b00};
        vecs[2]  = '{1'b1, 10'd10, 1'b1, 1'b0, 1'b0, 8'd255, 8'd1,   10'd1023, 10'd10,   2'b01};
        vecs[3]  = '{1'b0, 10'd0,  1'b0, 1'b1, 1'b1, 8'd255, 8'd1,   10'd102,  10'd1013, 2'b01};
        vecs[4]  = '{1'b1, 10'd5,  1'b1, 1'b0, 1'b0, 8'd50,  8'd100, 10'd250,  10'd500,  2'b00};
        vecs[5]  = '{1'b0, 10'd0,  1'b0, 1'b0, 1'b0, 8'd100, 8'd255, 10'd500,  10'd1023, 2'b10};
        vecs[6]  = '{1'b0, 10'd0,  1'b0, 1'b0, 1'b1, 8'd0,   8'd0,   10'd1023, 10'd1023, 2'b00};
        vecs[7]  = '{1'b0, 10'd0,  1'b0, 1'b0, 1'b0, 8'd204, 8'd205, 10'd1020, 10'd1023, 2'b10};
        vecs[8]  = '{1'b0, 10'd0,  1'b0, 1'b0, 1'b1, 8'd204, 8'd205, 10'd102,  10'd102,  2'b10};
        vecs[9]  = '{1'b1, 10'd11, 1'b1, 1'b0, 1'b0, 8'd93,  8'd94,  10'd1023, 10'd1023, 2'b10};
        vecs[10] = '{1'b1, 10'd8,  1'b1, 1'b1, 1'b1, 8'd115, 8'd116, 10'd103,  10'd102,  2'b00};

        rst_n       = 1'b0;
        mode        = 1'b0;
        inv_ac_in   = '0;
        inv_ac_load = 1'b0;
        in_valid    = 1'b0;
        in_sof      = 1'b0;
        in_eol      = 1'b0;
        in_fc       = '0;
        out_ready   = 1'b1;

        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_sat",   32'(out_sat),   32'd0);
        check("rst_out_sof",   32'(out_sof),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < NV; k++) begin
            send_beat(vecs[k].ld, vecs[k].inv, vecs[k].sof, vecs[k].eol, vecs[k].md,
                      vecs[k].fc0, vecs[k].fc1);
            expect_out(vecs[k].e0, vecs[k].e1, vecs[k].esat, vecs[k].sof, vecs[k].eol,
                       $sformatf("vec%0d", k), lat);
            if (k == 0) check("latency", 32'(lat), 32'd3);
        end

        // Streaming 16 beats with a 5-cycle downstream stall; Inv_Ac=4 arrives via pending.
        pulse_load(10'd4);
        cyc     = 0;
        tx      = 0;
        rx      = 0;
        saw_low = 1'b0;
        while (rx < 16 && cyc < 100) begin
            out_ready = !(cyc >= 6 && cyc < 11);
            if (tx < 16) begin
                in_valid = 1'b1;
                in_sof   = (tx == 0);
                mode     = 1'b0;
                in_fc    = {8'(15 - tx), 8'(tx)};
            end else begin
                in_valid = 1'b0;
                in_sof   = 1'b0;
            end
            #1;
            if (!out_ready && !in_ready) saw_low = 1'b1;
            if (out_valid) begin
                if (rx < 16) begin
                    check($sformatf("stream%0d_lane0", rx), 32'(out_data[9:0]),   32'(4 * rx));
                    check($sformatf("stream%0d_lane1", rx), 32'(out_data[19:10]), 32'(4 * (15 - rx)));
                end
                if (out_ready) rx++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) tx++;
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        check("stream_rx_count", 32'(rx), 32'd16);
        check("stream_tx_count", 32'(tx), 32'd16);
        check("stall_in_ready_low", 32'(saw_low), 32'd1);
        extra = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) extra = 1'b1;
            @(negedge clk);
        end
        check("stream_no_dup", 32'(extra), 32'd0);

        // Mid-frame load must wait for the next sof; later loads overwrite pending.
        pulse_load(10'd8);
        send_beat(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 8'd10, 8'd0);
        expect_out(10'd40, 10'd0, 2'b00, 1'b0, 1'b0, "midload_pre", lat);
        send_beat(1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 8'd10, 8'd0);
        expect_out(10'd80, 10'd0, 2'b00, 1'b1, 1'b0, "midload_sof", lat);
        send_beat(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 8'd10, 8'd0);
        expect_out(10'd80, 10'd0, 2'b00, 1'b0, 1'b0, "midload_post", lat);
        pulse_load(10'd6);
        pulse_load(10'd7);
        send_beat(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 8'd10, 8'd0);
        expect_out(10'd80, 10'd0, 2'b00, 1'b0, 1'b0, "overwrite_pre", lat);
        send_beat(1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 8'd10, 8'd0);
        expect_out(10'd70, 10'd0, 2'b00, 1'b1, 1'b0, "overwrite_sof", lat);

        // Three beats in flight, then asynchronous reset.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        mode      = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_fc = {8'd0, 8'(i)};
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("inflight_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data",  32'(out_data),  32'd0);
        check("midrst_out_sat",   32'(out_sat),   32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        extra     = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) extra = 1'b1;
        end
        check("midrst_no_stale", 32'(extra), 32'd0);
        send_beat(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 8'd100, 8'd255);
        expect_out(10'd0, 10'd0, 2'b00, 1'b0, 1'b0, "postrst_prod", lat);
        send_beat(1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 8'd100, 8'd255);
        expect_out(10'd1023, 10'd1023, 2'b00, 1'b0, 1'b0, "postrst_trans", lat);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
